ao_response_checker: RTL and testbench
======================================

Name: ao_response_checker

Overview:
- Synthesizable response-side companion to the combinational gate stimulus benches.
- Accepts one applied input vector at a time and waits a programmable settle interval. It then compares the reference gate output against the DUT gate output and accumulates pass/fail statistics.
- Sits between an on-chip pattern source and the AO gate pair under test; results are readable at end of run.

Parameters:
- NIN, 3, width of applied input vector (gate inputs a,b,c).
- NOUT, 1, width of compared outputs.
- SETTLE, 2, clock cycles waited after vector acceptance before sampling outputs (0..15).
- CW, 8, width of vector and error counters.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a run (accepted in IDLE or DONE).
- vec_valid  input  1  source presents a vector.
- vec_in  input  NIN  vector currently applied to both gates.
- vec_last  input  1  qualifies final vector of the run.
- ready  output  1  checker can accept a vector this cycle.
- ref_out  input  NOUT  reference gate output.
- dut_out  input  NOUT  DUT gate output.
- busy  output  1  run in progress.
- done  output  1  run complete; held until next start or rst.
- pass  output  1  valid with done; 1 iff err_count==0.
- vec_count  output  CW  vectors compared this run.
- err_count  output  CW  mismatching vectors this run.
- first_fail_vec  output  NIN  vec_in of first mismatch.
- first_fail_idx  output  CW  vec_count value at first mismatch (0-based).

Behaviour:
- Reset (rst high at a clk edge), from any state including mid-run:
  - state=IDLE; ready=0, busy=0, done=0, pass=0.
  - vec_count, err_count, first_fail_vec, first_fail_idx all 0.
- Only a start pulse restarts a run after reset.
- State IDLE: ready=0, busy=0. start -> clear all counters/captures, go ACCEPT.
- State ACCEPT: ready=1, busy=1.
  - vec_valid&&ready at edge -> latch vec_in and vec_last, load settle counter=SETTLE, go SETTLE.
  - The source must hold vec_in stable until ready reasserts.
- State SETTLE: ready=0.
  - Counter decrements each cycle; when counter==0, go CMP.
  - SETTLE=0 passes through after one cycle.
- State CMP (one cycle): mismatch = OR-reduce(ref_out XOR dut_out), sampled this cycle. At the following edge:
  - vec_count increments, saturating at 2^CW-1.
  - On mismatch, err_count increments, also saturating.
  - On the first mismatch of the run (err_count==0 before increment), capture first_fail_vec=latched vector and first_fail_idx=vec_count (pre-increment).
  - Next state: DONE if latched vec_last=1, else ACCEPT.
- Latency: ready low for exactly SETTLE+1 cycles after acceptance. Counters update SETTLE+1 edges after the accepting edge.
- State DONE: done=1, busy=0, ready=0, pass=(err_count==0). Counters and captures held stable.
  - start -> clear and go ACCEPT; done drops at that edge.
- start while busy (ACCEPT/SETTLE/CMP) is ignored.
- vec_valid outside ACCEPT is ignored.
- Saturation: counters never wrap. If vec_count saturates, err_count still counts independently up to its own saturation.
- X/Z on ref_out or dut_out compares as mismatch is not required; behaviour for X/Z inputs is undefined for synthesis.

Optional Feature:
- Macro: AO_CHECK_STOP_ON_FAIL_EN.
- Defined: a mismatch in CMP forces the next state to DONE regardless of vec_last. Counters update normally, so err_count=1, and vec_count includes the failing vector.
- Not defined: the run always continues to the vector flagged vec_last.

Test Plan:
- rst, then start; apply 8 vectors 000..111 (111 with vec_last), with ref_out==dut_out=(a&b)|c -> done=1, pass=1, vec_count=8, err_count=0, first_fail_idx=0.
- Same sweep, dut_out inverted for vectors 011 and 110 -> err_count=2, first_fail_vec=011, first_fail_idx=3, pass=0.
- SETTLE=2: accept at edge E0 -> ready low for 3 cycles, reasserts after E0+3, vec_count increments at E0+3. Also repeat with SETTLE=0 -> ready low exactly 1 cycle.
- rst asserted during SETTLE of vector 5 -> next cycle all outputs 0, state IDLE. A following vec_valid is ignored until start.
- CW=2, 5 vectors all mismatching -> vec_count=3 and err_count=3 (saturated, no wrap). A start from DONE clears both to 0.
- With AO_CHECK_STOP_ON_FAIL_EN, mismatch on vector index 2 of 8 -> done=1 after that CMP, vec_count=3, err_count=1, first_fail_idx=2.

Source files
------------

// File: rtl/ao_response_checker.sv
// ao_response_checker
// Response-side checker for the AO gate pair under test. Accepts one applied
// vector at a time, waits a settle interval, then compares the reference and
// DUT gate outputs and accumulates run statistics.
// Optional build macro AO_CHECK_STOP_ON_FAIL_EN: when defined, the first
// mismatching vector ends the run (DONE) regardless of vec_last.
module ao_response_checker #(
  parameter int NIN    = 3,
  parameter int NOUT   = 1,
  parameter int SETTLE = 2,
  parameter int CW     = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            vec_valid,
  input  logic [NIN-1:0]  vec_in,
  input  logic            vec_last,
  output logic            ready,
  input  logic [NOUT-1:0] ref_out,
  input  logic [NOUT-1:0] dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [CW-1:0]   vec_count,
  output logic [CW-1:0]   err_count,
  output logic [NIN-1:0]  first_fail_vec,
  output logic [CW-1:0]   first_fail_idx
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_SETTLE = 3'd2,
    S_CMP    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // The CMP cycle itself counts as the last settle cycle, so the counter is
  // loaded with SETTLE-1 and SETTLE==0 skips the settle state entirely. This
  // keeps ready low for exactly SETTLE+1 cycles after acceptance.
  localparam logic [3:0]    SETTLE_LOAD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
  localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};

  state_t          state_r;
  logic [3:0]      settle_cnt_r;
  logic [NIN-1:0]  vec_r;
  logic            last_r;
  logic            ready_r;
  logic            busy_r;
  logic            done_r;
  logic            pass_r;
  logic [CW-1:0]   vec_count_r;
  logic [CW-1:0]   err_count_r;
  logic [NIN-1:0]  ff_vec_r;
  logic [CW-1:0]   ff_idx_r;

  logic            mismatch_s;
  logic            first_fail_s;
  logic            stop_s;
  logic [CW-1:0]   vec_nxt_s;
  logic [CW-1:0]   err_nxt_s;

  // Compare result and saturating next-count values used in the CMP cycle.
  always_comb begin
    mismatch_s   = |(ref_out ^ dut_out);
    first_fail_s = mismatch_s && (err_count_r == CNT_ZERO);
    if (vec_count_r == CNT_MAX) begin
      vec_nxt_s = vec_count_r;
    end else begin
      vec_nxt_s = vec_count_r + {{(CW-1){1'b0}}, 1'b1};
    end
    if (mismatch_s && (err_count_r != CNT_MAX)) begin
      err_nxt_s = err_count_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      err_nxt_s = err_count_r;
    end
`ifdef AO_CHECK_STOP_ON_FAIL_EN
    stop_s = last_r || mismatch_s;
`else
    stop_s = last_r;
`endif
  end

  // Run control FSM with registered handshake/status outputs and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      settle_cnt_r <= 4'd0;
      vec_r        <= {NIN{1'b0}};
      last_r       <= 1'b0;
      ready_r      <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      vec_count_r  <= CNT_ZERO;
      err_count_r  <= CNT_ZERO;
      ff_vec_r     <= {NIN{1'b0}};
      ff_idx_r     <= CNT_ZERO;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_r     <= S_ACCEPT;
            ready_r     <= 1'b1;
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            vec_count_r <= CNT_ZERO;
            err_count_r <= CNT_ZERO;
            ff_vec_r    <= {NIN{1'b0}};
            ff_idx_r    <= CNT_ZERO;
          end
        end
        S_ACCEPT: begin
          if (vec_valid) begin
            vec_r        <= vec_in;
            last_r       <= vec_last;
            settle_cnt_r <= SETTLE_LOAD;
            ready_r      <= 1'b0;
            if (SETTLE == 0) begin
              state_r <= S_CMP;
            end else begin
              state_r <= S_SETTLE;
            end
          end
        end
        S_SETTLE: begin
          if (settle_cnt_r == 4'd0) begin
            state_r <= S_CMP;
          end else begin
            settle_cnt_r <= settle_cnt_r - 4'd1;
          end
        end
        S_CMP: begin
          vec_count_r <= vec_nxt_s;
          err_count_r <= err_nxt_s;
          if (first_fail_s) begin
            ff_vec_r <= vec_r;
            ff_idx_r <= vec_count_r;
          end
          if (stop_s) begin
            state_r <= S_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            pass_r  <= (err_nxt_s == CNT_ZERO);
          end else begin
            state_r <= S_ACCEPT;
            ready_r <= 1'b1;
          end
        end
        default: begin
          state_r <= S_IDLE;
          ready_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          pass_r  <= 1'b0;
        end
      endcase
    end
  end

  assign ready          = ready_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign vec_count      = vec_count_r;
  assign err_count      = err_count_r;
  assign first_fail_vec = ff_vec_r;
  assign first_fail_idx = ff_idx_r;

endmodule

// File: tb/tb_ao_response_checker.sv
// Directed bench for ao_response_checker. Three instances: default (SETTLE=2,
// CW=8), SETTLE=0, and CW=2 for saturation. Gate model: (a&b)|c with a=bit2.
module tb_ao_response_checker;

  logic       clk;
  logic       rst;
  logic [2:0] start_v, valid_v, last_v, flip_v;
  logic [2:0] vin_v [3];
  logic [2:0] ref_v, dut_v;
  logic [2:0] ready_v, busy_v, done_v, pass_v;
  logic [7:0] vc0, ec0, ffi0, vc1, ec1, ffi1;
  logic [1:0] vc2, ec2, ffi2;
  logic [2:0] ffv0, ffv1, ffv2;

  int vectors;
  int miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference gate model feeding both compared outputs; flip injects DUT error.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      ref_v[k] = (vin_v[k][2] & vin_v[k][1]) | vin_v[k][0];
      dut_v[k] = ref_v[k] ^ flip_v[k];
    end
  end

  ao_response_checker #(.NIN(3), .NOUT(1), .SETTLE(2), .CW(8)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .vec_valid(valid_v[0]),
    .vec_in(vin_v[0]), .vec_last(last_v[0]), .ready(ready_v[0]),
    .ref_out(ref_v[0]), .dut_out(dut_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .vec_count(vc0), .err_count(ec0),
    .first_fail_vec(ffv0), .first_fail_idx(ffi0));

  ao_response_checker #(.NIN(3), .NOUT(1), .SETTLE(0), .CW(8)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .vec_valid(valid_v[1]),
    .vec_in(vin_v[1]), .vec_last(last_v[1]), .ready(ready_v[1]),
    .ref_out(ref_v[1]), .dut_out(dut_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .vec_count(vc1), .err_count(ec1),
    .first_fail_vec(ffv1), .first_fail_idx(ffi1));

  ao_response_checker #(.NIN(3), .NOUT(1), .SETTLE(2), .CW(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .vec_valid(valid_v[2]),
    .vec_in(vin_v[2]), .vec_last(last_v[2]), .ready(ready_v[2]),
    .ref_out(ref_v[2]), .dut_out(dut_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .pass(pass_v[2]), .vec_count(vc2), .err_count(ec2),
    .first_fail_vec(ffv2), .first_fail_idx(ffi2));

  task automatic pulse_start(input int k);
    @(negedge clk);
    start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
  endtask

  // Waits for ready (or done, when the run ended early), then offers one vector.
  task automatic apply_vec(input int k, input logic [2:0] v, input logic last, input logic flip);
    int n;
    n = 0;
    while (!ready_v[k] && !done_v[k] && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!ready_v[k] && !done_v[k]) begin
      vectors++; miscompares++;
      $display("FAIL ready_timeout inst=%0d", k);
    end else if (ready_v[k]) begin
      valid_v[k] = 1'b1;
      vin_v[k]   = v;
      last_v[k]  = last;
      flip_v[k]  = flip;
      @(negedge clk);
      valid_v[k] = 1'b0;
    end
  endtask

  task automatic wait_done(input int k);
    int n;
    n = 0;
    while (!done_v[k] && n < 100) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (done_v[k] !== 1'b1) begin
      miscompares++;
      $display("FAIL done_timeout inst=%0d got=%b want=1", k, done_v[k]);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({ready_v, busy_v, done_v, pass_v} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_flags got=%h want=000", {ready_v, busy_v, done_v, pass_v});
    end
    vectors++;
    if ({vc0, ec0, ffi0, ffv0} !== 27'd0) begin
      miscompares++;
      $display("FAIL reset_counts got=%h want=0", {vc0, ec0, ffi0, ffv0});
    end
  endtask

  task automatic test_sweep_pass;
    pulse_start(0);
    for (int i = 0; i < 8; i++) apply_vec(0, 3'(i), (i == 7), 1'b0);
    wait_done(0);
    vectors++;
    if ({pass_v[0], busy_v[0]} !== 2'b10) begin
      miscompares++;
      $display("FAIL sweep_pass_flags got=%b want=10", {pass_v[0], busy_v[0]});
    end
    vectors++;
    if (vc0 !== 8'd8 || ec0 !== 8'd0 || ffi0 !== 8'd0) begin
      miscompares++;
      $display("FAIL sweep_pass_counts got=%0d/%0d/%0d want=8/0/0", vc0, ec0, ffi0);
    end
  endtask

  task automatic test_sweep_fail;
    logic [7:0] exp_vc, exp_ec;
`ifdef AO_CHECK_STOP_ON_FAIL_EN
    exp_vc = 8'd4; exp_ec = 8'd1;
`else
    exp_vc = 8'd8; exp_ec = 8'd2;
`endif
    pulse_start(0);
    for (int i = 0; i < 8; i++) apply_vec(0, 3'(i), (i == 7), (i == 3 || i == 6));
    wait_done(0);
    vectors++;
    if (vc0 !== exp_vc || ec0 !== exp_ec || pass_v[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL sweep_fail_counts got=%0d/%0d pass=%b want=%0d/%0d pass=0",
               vc0, ec0, pass_v[0], exp_vc, exp_ec);
    end
    vectors++;
    if (ffv0 !== 3'b011 || ffi0 !== 8'd3) begin
      miscompares++;
      $display("FAIL sweep_fail_capture got=%b/%0d want=011/3", ffv0, ffi0);
    end
  endtask

  task automatic test_latency;
    pulse_start(0);
    apply_vec(0, 3'b101, 1'b0, 1'b0);
    vectors++;
    if (ready_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL lat_e0 ready=%b busy=%b want ready=0 busy=1", ready_v[0], busy_v[0]);
    end
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (ready_v[0] !== 1'b0 || vc0 !== 8'd0) begin
      miscompares++;
      $display("FAIL lat_e2 ready=%b vc=%0d want ready=0 vc=0", ready_v[0], vc0);
    end
    @(negedge clk);
    vectors++;
    if (ready_v[0] !== 1'b1 || vc0 !== 8'd1) begin
      miscompares++;
      $display("FAIL lat_e3 ready=%b vc=%0d want ready=1 vc=1", ready_v[0], vc0);
    end
    apply_vec(0, 3'b000, 1'b1, 1'b0);
    wait_done(0);
    // SETTLE=0 instance: ready low for exactly one cycle.
    pulse_start(1);
    apply_vec(1, 3'b110, 1'b0, 1'b0);
    vectors++;
    if (ready_v[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL lat0_e0 ready=%b want=0", ready_v[1]);
    end
    @(negedge clk);
    vectors++;
    if (ready_v[1] !== 1'b1 || vc1 !== 8'd1) begin
      miscompares++;
      $display("FAIL lat0_e1 ready=%b vc=%0d want ready=1 vc=1", ready_v[1], vc1);
    end
    apply_vec(1, 3'b100, 1'b1, 1'b1);
    wait_done(1);
    vectors++;
    if (ec1 !== 8'd1 || ffi1 !== 8'd1 || ffv1 !== 3'b100 || pass_v[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL lat0_capture got=%0d/%0d/%b pass=%b want=1/1/100 pass=0",
               ec1, ffi1, ffv1, pass_v[1]);
    end
  endtask

  task automatic test_reset_mid_run;
    pulse_start(0);
    for (int i = 0; i < 5; i++) apply_vec(0, 3'(i), 1'b0, 1'b0);
    apply_vec(0, 3'd5, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({ready_v[0], busy_v[0], done_v[0], pass_v[0]} !== 4'b0000 ||
        {vc0, ec0, ffi0, ffv0} !== 27'd0) begin
      miscompares++;
      $display("FAIL midrun_reset flags=%b counts=%h want 0",
               {ready_v[0], busy_v[0], done_v[0], pass_v[0]}, {vc0, ec0, ffi0, ffv0});
    end
    valid_v[0] = 1'b1; vin_v[0] = 3'b111; last_v[0] = 1'b1;
    repeat (4) @(negedge clk);
    valid_v[0] = 1'b0;
    vectors++;
    if (ready_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || vc0 !== 8'd0) begin
      miscompares++;
      $display("FAIL idle_ignore ready=%b busy=%b done=%b vc=%0d want 0/0/0/0",
               ready_v[0], busy_v[0], done_v[0], vc0);
    end
    pulse_start(0);
    apply_vec(0, 3'b010, 1'b1, 1'b1);
    wait_done(0);
    vectors++;
    if (vc0 !== 8'd1 || ec0 !== 8'd1 || ffv0 !== 3'b010 || ffi0 !== 8'd0) begin
      miscompares++;
      $display("FAIL restart_run got=%0d/%0d/%b/%0d want=1/1/010/0", vc0, ec0, ffv0, ffi0);
    end
  endtask

  task automatic test_saturation;
    logic [1:0] exp_c;
`ifdef AO_CHECK_STOP_ON_FAIL_EN
    exp_c = 2'd1;
`else
    exp_c = 2'd3;
`endif
    pulse_start(2);
    for (int i = 0; i < 5; i++) apply_vec(2, 3'(i + 1), (i == 4), 1'b1);
    wait_done(2);
    vectors++;
    if (vc2 !== exp_c || ec2 !== exp_c || pass_v[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL saturate got=%0d/%0d pass=%b want=%0d/%0d pass=0",
               vc2, ec2, pass_v[2], exp_c, exp_c);
    end
    vectors++;
    if (ffv2 !== 3'b001 || ffi2 !== 2'd0) begin
      miscompares++;
      $display("FAIL saturate_capture got=%b/%0d want=001/0", ffv2, ffi2);
    end
    pulse_start(2);
    vectors++;
    if (vc2 !== 2'd0 || ec2 !== 2'd0 || done_v[2] !== 1'b0 || busy_v[2] !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_clear got=%0d/%0d done=%b busy=%b want=0/0 done=0 busy=1",
               vc2, ec2, done_v[2], busy_v[2]);
    end
    apply_vec(2, 3'b000, 1'b1, 1'b0);
    wait_done(2);
  endtask

  task automatic test_stop_on_fail;
    logic [7:0] exp_vc;
`ifdef AO_CHECK_STOP_ON_FAIL_EN
    exp_vc = 8'd3;
`else
    exp_vc = 8'd8;
`endif
    pulse_start(0);
    for (int i = 0; i < 8; i++) apply_vec(0, 3'(i), (i == 7), (i == 2));
    wait_done(0);
    vectors++;
    if (vc0 !== exp_vc || ec0 !== 8'd1 || ffi0 !== 8'd2 || ffv0 !== 3'b010) begin
      miscompares++;
      $display("FAIL stop_on_fail got=%0d/%0d/%0d/%b want=%0d/1/2/010",
               vc0, ec0, ffi0, ffv0, exp_vc);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    start_v = 3'b000; valid_v = 3'b000; last_v = 3'b000; flip_v = 3'b000;
    for (int k = 0; k < 3; k++) vin_v[k] = 3'b000;
    test_reset;
    test_sweep_pass;
    test_sweep_fail;
    test_latency;
    test_reset_mid_run;
    test_saturation;
    test_stop_on_fail;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
